// File: rtl/mod_counter_prog_if.sv
// Control and status bundle for one programmable-modulus counter stage.
// The counter itself takes the slave side; the controller or parent stage takes master.
interface mod_counter_prog_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
);
    logic              en;
    logic              up;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  mod_val;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              carry_out;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output en, up, load, load_val, mod_val,
        input  count, tc, carry_out, wrap_cnt
    );

    modport slave (
        input  en, up, load, load_val, mod_val,
        output count, tc, carry_out, wrap_cnt
    );
endinterface

// File: rtl/mod_counter_prog.sv
// Up/down counter modulo (mod_val+1) with synchronous load, registered terminal-count
// pulse, combinational cascade carry and a saturating wrap-event counter.
module mod_counter_prog #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mod_counter_prog_if.slave    bus
);

    logic [WIDTH-1:0]  count_q;
    logic              tc_q;
    logic [WRAP_W-1:0] wrap_cnt_q;

    logic              at_top;
    logic              at_zero;
    logic              wrap_hit;
    logic [WIDTH-1:0]  count_step;

    // A count loaded above mod_val counts as "at top" going up, so it wraps to 0
    // rather than running on through 2^WIDTH.
    always_comb begin
        at_top     = (count_q >= bus.mod_val);
        at_zero    = (count_q == '0);
        wrap_hit   = bus.up ? at_top : at_zero;
        count_step = count_q;
        if (bus.up) begin
            count_step = at_top ? '0 : count_q + WIDTH'(1);
        end else if (at_zero || count_q > bus.mod_val) begin
            count_step = bus.mod_val;
        end else begin
            count_step = count_q - WIDTH'(1);
        end
    end

    // carry_out doubles as this stage's wrap event, so a cascaded stage using it as
    // enable advances on exactly the edge at which this stage wraps.
    assign bus.carry_out = bus.en & ~bus.load & ~rst & wrap_hit;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            wrap_cnt_q <= '0;
        end else if (bus.load) begin
            count_q <= bus.load_val;
            tc_q    <= 1'b0;
        end else if (bus.en) begin
            count_q <= count_step;
            tc_q    <= wrap_hit;
            if (wrap_hit && wrap_cnt_q != '1) begin
                wrap_cnt_q <= wrap_cnt_q + WRAP_W'(1);
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_mod_counter_prog.sv
// Scoreboard bench for mod_counter_prog: a behavioural model pushes expected outputs
// per cycle, each scenario task pops and compares after the edge.
module tb_mod_counter_prog;

    logic clk = 1'b0;
    logic rst;

    mod_counter_prog_if #(.WIDTH(4), .WRAP_W(8)) bus0 ();
    mod_counter_prog_if #(.WIDTH(4), .WRAP_W(8)) bus1 ();

    mod_counter_prog #(.WIDTH(4), .WRAP_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mod_counter_prog #(.WIDTH(4), .WRAP_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.en = bus0.carry_out;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] count;
        logic       tc;
        logic [7:0] wrap;
    } exp_t;

    exp_t sb[$];
    exp_t exp_v;
    int   m_count;
    int   m_wrap;
    logic exp_carry;
    logic obs_carry;
    int   n_vec;
    int   n_miss;

    // Drive one cycle of stage-0 stimulus, predict its outcome, then advance past the edge.
    task automatic cycle(input logic r, input logic ld, input logic [3:0] lv,
                         input logic e, input logic u, input logic [3:0] mv);
        exp_t x;
        bit   wrapped;
        rst           = r;
        bus0.load     = ld;
        bus0.load_val = lv;
        bus0.en       = e;
        bus0.up       = u;
        bus0.mod_val  = mv;
        exp_carry = e & ~ld & ~r & (u ? (m_count >= int'(mv)) : (m_count == 0));
        wrapped = 1'b0;
        if (r) begin
            m_count = 0;
            m_wrap  = 0;
        end else if (ld) begin
            m_count = int'(lv);
        end else if (e) begin
            if (u) begin
                if (m_count >= int'(mv)) begin m_count = 0; wrapped = 1'b1; end
                else m_count = m_count + 1;
            end else begin
                if (m_count == 0) begin m_count = int'(mv); wrapped = 1'b1; end
                else if (m_count > int'(mv)) m_count = int'(mv);
                else m_count = m_count - 1;
            end
        end
        if (wrapped && m_wrap < 255) m_wrap = m_wrap + 1;
        x.count = 4'(m_count);
        x.tc    = wrapped;
        x.wrap  = 8'(m_wrap);
        sb.push_back(x);
        #2 obs_carry = bus0.carry_out;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9);
            exp_v = sb.pop_front();
            n_vec++;
            if (bus0.count !== exp_v.count || bus0.tc !== exp_v.tc ||
                bus0.wrap_cnt !== exp_v.wrap || obs_carry !== exp_carry) begin
                n_miss++;
                $display("FAIL reset[%0d]: count=%0d tc=%b wrap=%0d carry=%b, want %0d %b %0d %b",
                         i, bus0.count, bus0.tc, bus0.wrap_cnt, obs_carry,
                         exp_v.count, exp_v.tc, exp_v.wrap, exp_carry);
            end
        end
    endtask

    task automatic test_count_up();
        int tc_seen = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9);
            exp_v = sb.pop_front();
            n_vec++;
            if (bus0.tc === 1'b1) tc_seen++;
            if (bus0.count !== exp_v.count || bus0.tc !== exp_v.tc ||
                bus0.wrap_cnt !== exp_v.wrap || obs_carry !== exp_carry) begin
                n_miss++;
                $display("FAIL count_up[%0d]: count=%0d tc=%b wrap=%0d carry=%b, want %0d %b %0d %b",
                         i, bus0.count, bus0.tc, bus0.wrap_cnt, obs_carry,
                         exp_v.count, exp_v.tc, exp_v.wrap, exp_carry);
            end
        end
        n_vec++;
        if (bus0.count !== 4'd4 || bus0.wrap_cnt !== 8'd2 || tc_seen != 2) begin
            n_miss++;
            $display("FAIL count_up_end: count=%0d wrap=%0d tc_pulses=%0d, want 4 2 2",
                     bus0.count, bus0.wrap_cnt, tc_seen);
        end
    endtask

    task automatic test_count_down();
        logic [3:0] seq [0:8] = '{4'd2, 4'd1, 4'd0, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        for (int i = 0; i < 9; i++) begin
            if (i == 0) cycle(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 4'd5);
            else        cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5);
            exp_v = sb.pop_front();
            n_vec++;
            if (bus0.count !== exp_v.count || bus0.count !== seq[i] || bus0.tc !== exp_v.tc ||
                bus0.wrap_cnt !== exp_v.wrap || obs_carry !== exp_carry) begin
                n_miss++;
                $display("FAIL count_down[%0d]: count=%0d tc=%b wrap=%0d carry=%b, want %0d %b %0d %b",
                         i, bus0.count, bus0.tc, bus0.wrap_cnt, obs_carry,
                         seq[i], exp_v.tc, exp_v.wrap, exp_carry);
            end
        end
    endtask

    task automatic test_load_above_mod();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: cycle(1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 4'd3);
                1: cycle(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd3);
                2: cycle(1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 4'd3);
                default: cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3);
            endcase
            exp_v = sb.pop_front();
            n_vec++;
            if (bus0.count !== exp_v.count || bus0.tc !== exp_v.tc ||
                bus0.wrap_cnt !== exp_v.wrap || obs_carry !== exp_carry) begin
                n_miss++;
                $display("FAIL load_above[%0d]: count=%0d tc=%b wrap=%0d carry=%b, want %0d %b %0d %b",
                         i, bus0.count, bus0.tc, bus0.wrap_cnt, obs_carry,
                         exp_v.count, exp_v.tc, exp_v.wrap, exp_carry);
            end
        end
    endtask

    task automatic test_mod_zero();
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0);
            exp_v = sb.pop_front();
            n_vec++;
            if (bus0.count !== exp_v.count || bus0.tc !== exp_v.tc ||
                bus0.wrap_cnt !== exp_v.wrap || obs_carry !== exp_carry) begin
                n_miss++;
                $display("FAIL mod_zero[%0d]: count=%0d tc=%b wrap=%0d carry=%b, want %0d %b %0d %b",
                         i, bus0.count, bus0.tc, bus0.wrap_cnt, obs_carry,
                         exp_v.count, exp_v.tc, exp_v.wrap, exp_carry);
            end
        end
        n_vec++;
        if (bus0.wrap_cnt !== 8'd255 || bus0.count !== 4'd0) begin
            n_miss++;
            $display("FAIL mod_zero_sat: wrap=%0d count=%0d, want 255 0", bus0.wrap_cnt, bus0.count);
        end
    endtask

    task automatic test_load_on_wrap();
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9);
        void'(sb.pop_front());
        for (int i = 0; i < 16; i++) begin
            if (i == 9)       cycle(1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 4'd9);
            else if (i == 15) cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9);
            else              cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9);
            exp_v = sb.pop_front();
            n_vec++;
            if (bus0.count !== exp_v.count || bus0.tc !== exp_v.tc ||
                bus0.wrap_cnt !== exp_v.wrap || obs_carry !== exp_carry) begin
                n_miss++;
                $display("FAIL load_on_wrap[%0d]: count=%0d tc=%b wrap=%0d carry=%b, want %0d %b %0d %b",
                         i, bus0.count, bus0.tc, bus0.wrap_cnt, obs_carry,
                         exp_v.count, exp_v.tc, exp_v.wrap, exp_carry);
            end
            if (i == 9) begin
                n_vec++;
                if (bus0.count !== 4'd4 || bus0.tc !== 1'b0 || bus0.wrap_cnt !== 8'd0) begin
                    n_miss++;
                    $display("FAIL load_beats_wrap: count=%0d tc=%b wrap=%0d, want 4 0 0",
                             bus0.count, bus0.tc, bus0.wrap_cnt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9);
        void'(sb.pop_front());
        for (int k = 1; k <= 100; k++) begin
            cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9);
            exp_v = sb.pop_front();
            n_vec++;
            if (bus0.count !== exp_v.count || bus0.count !== 4'(k % 10) ||
                bus1.count !== 4'((k / 10) % 10) || bus1.tc !== (k % 100 == 0)) begin
                n_miss++;
                $display("FAIL cascade[%0d]: s0=%0d s1=%0d s1_tc=%b, want %0d %0d %b",
                         k, bus0.count, bus1.count, bus1.tc,
                         k % 10, (k / 10) % 10, (k % 100 == 0));
            end
        end
        n_vec++;
        if (bus1.wrap_cnt !== 8'd1 || bus0.wrap_cnt !== 8'd10) begin
            n_miss++;
            $display("FAIL cascade_wraps: s0=%0d s1=%0d, want 10 1", bus0.wrap_cnt, bus1.wrap_cnt);
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        m_count = 0;
        m_wrap = 0;
        rst = 1'b1;
        bus0.en = 1'b0;
        bus0.up = 1'b1;
        bus0.load = 1'b0;
        bus0.load_val = '0;
        bus0.mod_val = 4'd9;
        bus1.up = 1'b1;
        bus1.load = 1'b0;
        bus1.load_val = '0;
        bus1.mod_val = 4'd9;
        @(posedge clk);
        #1;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_above_mod();
        test_mod_zero();
        test_load_on_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
